// File: rtl/tm_q_binder.sv
// Free-queue client: binds flows to first-level queues on first enqueue, counts resident
// packets per queue and returns a queue ID to the free pool once it drains.
module tm_q_binder #(
    parameter int unsigned Q_NBITS    = 4,
    parameter int unsigned FLOW_NBITS = 6,
    parameter int unsigned CNT_NBITS  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enq_req_i,
    input  logic [FLOW_NBITS-1:0] enq_flow_id_i,
    output logic                  enq_ready_o,
    output logic                  enq_rsp_valid_o,
    output logic                  enq_rsp_ok_o,
    output logic [Q_NBITS-1:0]    enq_rsp_q_idx_o,
    input  logic                  deq_req_i,
    input  logic [Q_NBITS-1:0]    deq_q_idx_i,
    input  logic [Q_NBITS-1:0]    freeq_head_i,
    input  logic [Q_NBITS:0]      freeq_count_i,
    output logic                  get_q_req_o,
    output logic                  dec_freeq_count_o,
    output logic                  rel_q_valid_o,
    output logic [Q_NBITS-1:0]    rel_q_idx_o,
    output logic                  err_underflow_o
);

    localparam int unsigned NumQ     = 1 << Q_NBITS;
    localparam int unsigned NumFlows = 1 << FLOW_NBITS;
    localparam logic [Q_NBITS:0]     PoolFull = (Q_NBITS+1)'(NumQ);
    localparam logic [CNT_NBITS-1:0] CntMax   = '1;
    localparam logic [CNT_NBITS-1:0] CntOne   = CNT_NBITS'(1);

    typedef enum logic [1:0] {StInit, StRun, StAwait} state_e;

    state_e state_q, state_d;

    logic [NumFlows-1:0]   flow_valid_q, flow_valid_d;
    logic [Q_NBITS-1:0]    flow_qid_q [NumFlows];
    logic [Q_NBITS-1:0]    flow_qid_d [NumFlows];
    logic [CNT_NBITS-1:0]  cnt_q [NumQ];
    logic [CNT_NBITS-1:0]  cnt_d [NumQ];
    logic [FLOW_NBITS-1:0] owner_q [NumQ];
    logic [FLOW_NBITS-1:0] owner_d [NumQ];

    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_ok_q, rsp_ok_d;
    logic [Q_NBITS-1:0]    rsp_q_q, rsp_q_d;
    logic                  rel_valid_q, rel_valid_d;
    logic [Q_NBITS-1:0]    rel_q_q, rel_q_d;
    logic                  err_q, err_d;
    logic                  get_q;

    logic                  enq_acc, deq_act, hit, same_q;
    logic [Q_NBITS-1:0]    hit_q;

    assign enq_acc = enq_req_i & (state_q == StRun);
    assign deq_act = deq_req_i & (state_q != StInit);
    assign hit     = flow_valid_q[enq_flow_id_i];
    assign hit_q   = flow_qid_q[enq_flow_id_i];
    // An enqueue and a dequeue on the same bound queue cancel out: count and binding are kept.
    assign same_q  = enq_acc & hit & deq_act & (deq_q_idx_i == hit_q);

    always_comb begin
        state_d      = state_q;
        flow_valid_d = flow_valid_q;
        flow_qid_d   = flow_qid_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        rsp_valid_d  = 1'b0;
        rsp_ok_d     = rsp_ok_q;
        rsp_q_d      = rsp_q_q;
        rel_valid_d  = 1'b0;
        rel_q_d      = rel_q_q;
        err_d        = err_q;
        get_q        = 1'b0;

        unique case (state_q)
            StInit:  if (freeq_count_i == PoolFull) state_d = StRun;
            StRun:   state_d = StRun;
            StAwait: state_d = StRun;
            default: state_d = StInit;
        endcase

        if (deq_act) begin
            if (cnt_q[deq_q_idx_i] == '0) begin
                err_d = 1'b1;
            end else if (!same_q) begin
                cnt_d[deq_q_idx_i] = cnt_q[deq_q_idx_i] - CntOne;
                if (cnt_q[deq_q_idx_i] == CntOne) begin
                    rel_valid_d                        = 1'b1;
                    rel_q_d                            = deq_q_idx_i;
                    flow_valid_d[owner_q[deq_q_idx_i]] = 1'b0;
                end
            end
        end

        if (enq_acc) begin
            rsp_valid_d = 1'b1;
            if (hit) begin
                rsp_q_d = hit_q;
                if (same_q) begin
                    rsp_ok_d = 1'b1;
                end else if (cnt_q[hit_q] != CntMax) begin
                    cnt_d[hit_q] = cnt_q[hit_q] + CntOne;
                    rsp_ok_d     = 1'b1;
                end else begin
                    rsp_ok_d = 1'b0;
                end
            end else if (freeq_count_i != '0) begin
                get_q                       = 1'b1;
                flow_valid_d[enq_flow_id_i] = 1'b1;
                flow_qid_d[enq_flow_id_i]   = freeq_head_i;
                cnt_d[freeq_head_i]         = CntOne;
                owner_d[freeq_head_i]       = enq_flow_id_i;
                rsp_ok_d                    = 1'b1;
                rsp_q_d                     = freeq_head_i;
                // Give the pool one cycle to advance head/count before the next pop.
                state_d                     = StAwait;
            end else begin
                rsp_ok_d = 1'b0;
                rsp_q_d  = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StInit;
            flow_valid_q <= '0;
            flow_qid_q   <= '{default: '0};
            cnt_q        <= '{default: '0};
            owner_q      <= '{default: '0};
            rsp_valid_q  <= 1'b0;
            rsp_ok_q     <= 1'b0;
            rsp_q_q      <= '0;
            rel_valid_q  <= 1'b0;
            rel_q_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            flow_valid_q <= flow_valid_d;
            flow_qid_q   <= flow_qid_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_ok_q     <= rsp_ok_d;
            rsp_q_q      <= rsp_q_d;
            rel_valid_q  <= rel_valid_d;
            rel_q_q      <= rel_q_d;
            err_q        <= err_d;
        end
    end

    assign enq_ready_o       = (state_q == StRun);
    assign enq_rsp_valid_o   = rsp_valid_q;
    assign enq_rsp_ok_o      = rsp_ok_q;
    assign enq_rsp_q_idx_o   = rsp_q_q;
    assign get_q_req_o       = get_q;
    assign dec_freeq_count_o = get_q;
    assign rel_q_valid_o     = rel_valid_q;
    assign rel_q_idx_o       = rel_q_q;
    assign err_underflow_o   = err_q;

endmodule

// File: tb/tb_tm_q_binder.sv
// Bench for tm_q_binder: directed scenarios plus random traffic checked against a
// map/queue reference model that also plays the free-queue FIFO.
module tb_tm_q_binder;
    localparam int QN   = 3;
    localparam int FN   = 4;
    localparam int CN   = 2;
    localparam int NQ   = 1 << QN;
    localparam int NF   = 1 << FN;
    localparam int CMAX = (1 << CN) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enq_req;
    logic [FN-1:0] enq_flow_id;
    logic          enq_ready, enq_rsp_valid, enq_rsp_ok;
    logic [QN-1:0] enq_rsp_q_idx;
    logic          deq_req;
    logic [QN-1:0] deq_q_idx;
    logic [QN-1:0] freeq_head;
    logic [QN:0]   freeq_count;
    logic          get_q_req, dec_freeq_count, rel_q_valid, err_underflow;
    logic [QN-1:0] rel_q_idx;

    always #5 clk = ~clk;

    tm_q_binder #(.Q_NBITS(QN), .FLOW_NBITS(FN), .CNT_NBITS(CN)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .enq_req_i        (enq_req),
        .enq_flow_id_i    (enq_flow_id),
        .enq_ready_o      (enq_ready),
        .enq_rsp_valid_o  (enq_rsp_valid),
        .enq_rsp_ok_o     (enq_rsp_ok),
        .enq_rsp_q_idx_o  (enq_rsp_q_idx),
        .deq_req_i        (deq_req),
        .deq_q_idx_i      (deq_q_idx),
        .freeq_head_i     (freeq_head),
        .freeq_count_i    (freeq_count),
        .get_q_req_o      (get_q_req),
        .dec_freeq_count_o(dec_freeq_count),
        .rel_q_valid_o    (rel_q_valid),
        .rel_q_idx_o      (rel_q_idx),
        .err_underflow_o  (err_underflow)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: flow -> queue map (-1 = unbound), per-queue count/owner, free pool.
    int fmap [NF];
    int qcnt [NQ];
    int owner[NQ];
    int pool [$];
    int fill_next;
    bit m_init, m_await;
    bit exp_err, exp_rsp_v, exp_rsp_ok, exp_rel_v, exp_get, pend_rel;
    int exp_rsp_q, exp_rel_q, pend_rel_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (fmap[i]) fmap[i] = -1;
        foreach (qcnt[i]) begin qcnt[i] = 0; owner[i] = 0; end
        pool.delete();
        fill_next = 0;
        m_init = 1; m_await = 0;
        exp_err = 0; exp_rsp_v = 0; exp_rsp_ok = 0; exp_rel_v = 0; exp_get = 0; pend_rel = 0;
        exp_rsp_q = 0; exp_rel_q = 0; pend_rel_q = 0;
    endtask

    task automatic drive_pool();
        freeq_head  = (pool.size() > 0) ? QN'(pool[0]) : '0;
        freeq_count = (QN+1)'(pool.size());
    endtask

    task automatic check_reset_outputs();
        check("rst_enq_ready", enq_ready, 0);
        check("rst_get_q_req", get_q_req, 0);
        check("rst_dec_count", dec_freeq_count, 0);
        check("rst_rsp_valid", enq_rsp_valid, 0);
        check("rst_rsp_ok", enq_rsp_ok, 0);
        check("rst_rsp_q", enq_rsp_q_idx, 0);
        check("rst_rel_valid", rel_q_valid, 0);
        check("rst_rel_idx", rel_q_idx, 0);
        check("rst_err", err_underflow, 0);
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic cyc(input bit e, input int f, input bit d, input int q);
        bit ready, enq_eff, deq_eff, same;
        int hq, h;
        ready       = !m_init && !m_await;
        enq_req     = e && ready;
        enq_flow_id = FN'(f);
        deq_req     = d;
        deq_q_idx   = QN'(q);
        @(negedge clk);
        check("rsp_valid", enq_rsp_valid, exp_rsp_v);
        if (exp_rsp_v) begin
            check("rsp_ok", enq_rsp_ok, exp_rsp_ok);
            check("rsp_q_idx", enq_rsp_q_idx, exp_rsp_q);
        end
        check("rel_valid", rel_q_valid, exp_rel_v);
        if (exp_rel_v) check("rel_idx", rel_q_idx, exp_rel_q);
        check("err_underflow", err_underflow, exp_err);
        check("enq_ready", enq_ready, ready);

        enq_eff = e && ready;
        deq_eff = d && !m_init;
        hq      = fmap[f];
        same    = enq_eff && hq >= 0 && deq_eff && q == hq;
        exp_get = 0; exp_rsp_v = 0; exp_rel_v = 0;
        if (deq_eff) begin
            if (qcnt[q] == 0) exp_err = 1;
            else if (!same) begin
                qcnt[q]--;
                if (qcnt[q] == 0) begin
                    exp_rel_v = 1; exp_rel_q = q; fmap[owner[q]] = -1;
                end
            end
        end
        if (enq_eff) begin
            exp_rsp_v = 1;
            if (hq >= 0) begin
                exp_rsp_q = hq;
                if (same) exp_rsp_ok = 1;
                else if (qcnt[hq] < CMAX) begin qcnt[hq]++; exp_rsp_ok = 1; end
                else exp_rsp_ok = 0;
            end else if (pool.size() > 0) begin
                h = pool[0];
                exp_get = 1; fmap[f] = h; qcnt[h] = 1; owner[h] = f;
                exp_rsp_ok = 1; exp_rsp_q = h;
            end else begin
                exp_rsp_ok = 0; exp_rsp_q = 0;
            end
        end
        if (m_init) begin
            if (pool.size() == NQ) m_init = 0;
        end else if (m_await) m_await = 0;
        else if (exp_get) m_await = 1;
        check("get_q_req", get_q_req, exp_get);
        check("dec_freeq_count", dec_freeq_count, exp_get);

        @(posedge clk); #1;
        if (exp_get) void'(pool.pop_front());
        if (pend_rel) pool.push_back(pend_rel_q);
        pend_rel = exp_rel_v; pend_rel_q = exp_rel_q;
        if (fill_next < NQ) begin pool.push_back(fill_next); fill_next++; end
        drive_pool();
        enq_req = 0; deq_req = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0);
    endtask

    initial begin
        int live[$];
        int rq;
        bit rd;
        rst_n = 0; enq_req = 0; enq_flow_id = '0; deq_req = 0; deq_q_idx = '0;
        model_reset();
        drive_pool();
        #1 check_reset_outputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        idle(NQ + 3);

        // First enqueue allocates, second hits; two deqs drain and release; re-enqueue reallocates.
        cyc(1, 3, 0, 0); idle(1);
        cyc(1, 3, 0, 0);
        cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); idle(1);
        cyc(1, 3, 0, 0); idle(1);
        // Enqueue hit and dequeue on the same queue with count 1: stays bound.
        cyc(1, 3, 1, fmap[3]); idle(2);

        for (int n = 0; n < 400; n++) begin
            live.delete();
            foreach (qcnt[i]) if (qcnt[i] > 0) live.push_back(i);
            rd = ($urandom_range(0, 9) < 4) && live.size() > 0;
            rq = rd ? live[$urandom_range(0, live.size() - 1)] : 0;
            cyc($urandom_range(0, 1), $urandom_range(0, 9), rd, rq);
        end

        // Reset in the middle of traffic.
        rst_n = 0;
        #1 check_reset_outputs();
        model_reset();
        drive_pool();
        @(posedge clk); #1 rst_n = 1;
        idle(NQ + 3);

        // Exhaust the pool, then an unbound flow is dropped without a pop.
        for (int i = 0; i < NQ; i++) begin cyc(1, i, 0, 0); idle(1); end
        cyc(1, 9, 0, 0);
        // Saturate flow 0's counter.
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        // Drain flow 1's queue, then underflow it.
        rq = fmap[1];
        cyc(0, 0, 1, rq); idle(1);
        cyc(0, 0, 1, rq); idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
